// File: rtl/pll_cfg_pkg.sv
// Shared constants and FSM state type for the PLL reconfiguration sequencer.
package pll_cfg_pkg;

  localparam logic [5:0] ADDR_MODE   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h01;
  localparam logic [5:0] ADDR_START  = 6'h02;
  localparam logic [5:0] ADDR_N      = 6'h03;
  localparam logic [5:0] ADDR_M      = 6'h04;
  localparam logic [5:0] ADDR_C      = 6'h05;
  localparam logic [5:0] ADDR_K      = 6'h07;

  // 18-bit counter word: {bypass, odd, hi[7:0], lo[7:0]}
  localparam int CNT_W     = 18;
  localparam int CNT_LO_W  = 8;
  localparam int CNT_HI_W  = 8;
  localparam int CNT_ODD_W = 1;
  localparam int CNT_BYP_W = 1;
  localparam int CIDX_W    = 5;
  localparam int K_W       = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MODE,
    ST_WR_M,
    ST_WR_N,
    ST_WR_C,
    ST_WR_K,
    ST_START,
    ST_POLL,
    ST_LOCK,
    ST_FINISH,
    ST_FAIL
  } state_t;

endpackage

// File: rtl/pll_cfg_rom.sv
// Combinational extractor of M, N, C[idx] and K words for one preset from the packed tables.
module pll_cfg_rom
  import pll_cfg_pkg::*;
#(
  parameter int unsigned N_PRESETS = 3,
  parameter int unsigned N_CLOCKS  = 3,
  parameter logic [CNT_W*N_PRESETS-1:0]          PRESET_M = '0,
  parameter logic [CNT_W*N_PRESETS-1:0]          PRESET_N = '0,
  parameter logic [CNT_W*N_CLOCKS*N_PRESETS-1:0] PRESET_C = '0,
  parameter logic [K_W*N_PRESETS-1:0]            PRESET_K = '0
) (
  input  logic [3:0]        i_sel,
  input  logic [CIDX_W-1:0] i_idx,
  output logic [CNT_W-1:0]  o_m,
  output logic [CNT_W-1:0]  o_n,
  output logic [CNT_W-1:0]  o_c,
  output logic [K_W-1:0]    o_k
);

  always_comb begin
    o_m = '0;
    o_n = '0;
    o_c = '0;
    o_k = '0;
    if (int'(i_sel) < int'(N_PRESETS)) begin
      o_m = PRESET_M[CNT_W*int'(i_sel) +: CNT_W];
      o_n = PRESET_N[CNT_W*int'(i_sel) +: CNT_W];
      o_k = PRESET_K[K_W*int'(i_sel) +: K_W];
      if (int'(i_idx) < int'(N_CLOCKS))
        o_c = PRESET_C[CNT_W*(int'(i_sel)*int'(N_CLOCKS) + int'(i_idx)) +: CNT_W];
    end
  end

endmodule

// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer: writes a preset's counters over Avalon-MM, starts reconfig,
// polls for completion and waits for lock.
module pll_cfg_seq
  import pll_cfg_pkg::*;
#(
  parameter int unsigned N_PRESETS    = 3,
  parameter int unsigned N_CLOCKS     = 3,
  parameter logic [CNT_W*N_PRESETS-1:0]          PRESET_M = {N_PRESETS{18'h00808}},
  parameter logic [CNT_W*N_PRESETS-1:0]          PRESET_N = {N_PRESETS{18'h00101}},
  parameter logic [CNT_W*N_CLOCKS*N_PRESETS-1:0] PRESET_C = {(N_CLOCKS*N_PRESETS){18'h00404}},
  parameter logic [K_W*N_PRESETS-1:0]            PRESET_K = {N_PRESETS{32'h0}},
  parameter int unsigned POLL_TIMEOUT = 4096,
  parameter int unsigned LOCK_TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic [3:0]  cfg_sel,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  cur_preset,
  output logic        cur_valid,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  localparam int unsigned TMO_MAX = (POLL_TIMEOUT > LOCK_TIMEOUT) ? POLL_TIMEOUT : LOCK_TIMEOUT;
  localparam int TMO_W = (TMO_MAX > 2) ? $clog2(TMO_MAX) : 1;

  state_t             r_state;
  logic [3:0]         r_sel;
  logic [3:0]         r_cur;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_wr;
  logic               r_rd;
  logic [5:0]         r_addr;
  logic [31:0]        r_wdata;
  logic [CIDX_W-1:0]  r_cidx;
  logic [TMO_W-1:0]   r_tmo;
  logic [1:0]         r_lcnt;

  logic               w_wr_done;
  logic               w_rd_ok;
  logic [CIDX_W-1:0]  w_cidx_nxt;
  logic [CNT_W-1:0]   w_m;
  logic [CNT_W-1:0]   w_n;
  logic [CNT_W-1:0]   w_c;
  logic [K_W-1:0]     w_k;
  logic               w_unused_rd;

  assign w_wr_done   = r_wr & ~mgmt_waitrequest;
  assign w_rd_ok     = r_rd & ~mgmt_waitrequest & mgmt_readdata[0];
  assign w_unused_rd = ^mgmt_readdata[31:1];
  // ROM looks one C word ahead so the next write's data is ready at the completing edge
  assign w_cidx_nxt  = (r_state == ST_WR_C) ? r_cidx + 1'b1 : '0;

  pll_cfg_rom #(
    .N_PRESETS (N_PRESETS),
    .N_CLOCKS  (N_CLOCKS),
    .PRESET_M  (PRESET_M),
    .PRESET_N  (PRESET_N),
    .PRESET_C  (PRESET_C),
    .PRESET_K  (PRESET_K)
  ) u_rom (
    .i_sel (r_sel),
    .i_idx (w_cidx_nxt),
    .o_m   (w_m),
    .o_n   (w_n),
    .o_c   (w_c),
    .o_k   (w_k)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_cur   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cidx  <= '0;
      r_tmo   <= '0;
      r_lcnt  <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: if (cfg_req) begin
          r_sel <= cfg_sel;
          if (int'(cfg_sel) >= int'(N_PRESETS)) begin
            r_err   <= 1'b1;
            r_state <= ST_FAIL;
          end else if (r_valid && cfg_sel == r_cur) begin
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            r_busy  <= 1'b1;
            r_wr    <= 1'b1;
            r_addr  <= ADDR_MODE;
            r_wdata <= 32'd1;
            r_cidx  <= '0;
            r_state <= ST_MODE;
          end
        end
        ST_MODE: if (w_wr_done) begin
          r_addr  <= ADDR_M;
          r_wdata <= 32'(w_m);
          r_state <= ST_WR_M;
        end
        ST_WR_M: if (w_wr_done) begin
          r_addr  <= ADDR_N;
          r_wdata <= 32'(w_n);
          r_state <= ST_WR_N;
        end
        ST_WR_N: if (w_wr_done) begin
          r_addr  <= ADDR_C;
          r_wdata <= {9'b0, w_cidx_nxt, w_c};
          r_state <= ST_WR_C;
        end
        ST_WR_C: if (w_wr_done) begin
          if (int'(r_cidx) == int'(N_CLOCKS) - 1) begin
            r_cidx  <= '0;
            r_addr  <= ADDR_K;
            r_wdata <= w_k;
            r_state <= ST_WR_K;
          end else begin
            r_cidx  <= w_cidx_nxt;
            r_wdata <= {9'b0, w_cidx_nxt, w_c};
          end
        end
        ST_WR_K: if (w_wr_done) begin
          r_addr  <= ADDR_START;
          r_wdata <= '0;
          r_state <= ST_START;
        end
        ST_START: if (w_wr_done) begin
          r_wr    <= 1'b0;
          r_rd    <= 1'b1;
          r_addr  <= ADDR_STATUS;
          r_wdata <= '0;
          r_tmo   <= '0;
          r_state <= ST_POLL;
        end
        ST_POLL: begin
          if (w_rd_ok) begin
            r_rd    <= 1'b0;
            r_tmo   <= '0;
            r_lcnt  <= '0;
            r_state <= ST_LOCK;
          end else if (r_tmo == TMO_W'(POLL_TIMEOUT - 1)) begin
            r_rd    <= 1'b0;
            r_err   <= 1'b1;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_FAIL;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_LOCK: begin
          if (pll_locked && r_lcnt == 2'd3) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cur   <= r_sel;
            r_valid <= 1'b1;
            r_state <= ST_FINISH;
          end else if (r_tmo == TMO_W'(LOCK_TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_FAIL;
          end else begin
            r_tmo  <= r_tmo + 1'b1;
            r_lcnt <= pll_locked ? r_lcnt + 1'b1 : 2'd0;
          end
        end
        ST_FINISH, ST_FAIL: r_state <= ST_IDLE;
        default:            r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_err;
  assign cur_preset     = r_cur;
  assign cur_valid      = r_valid;
  assign mgmt_address   = r_addr;
  assign mgmt_write     = r_wr;
  assign mgmt_read      = r_rd;
  assign mgmt_writedata = r_wdata;

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Randomised bench for pll_cfg_seq: bus responder plus a transaction-list reference model.
module tb_pll_cfg_seq;

  localparam int NP   = 3;
  localparam int NC   = 3;
  localparam int PTMO = 64;
  localparam int LTMO = 256;

  localparam logic [53:0]  PM = {18'h00A0C, 18'h01414, 18'h00808};
  localparam logic [53:0]  PN = {18'h00302, 18'h20000, 18'h00101};
  localparam logic [161:0] PC = {18'h00909, 18'h10000, 18'h00706,
                                 18'h00605, 18'h20303, 18'h00404,
                                 18'h00B0A, 18'h00202, 18'h30101};
  localparam logic [95:0]  PK = {32'hCAFE_0003, 32'h8000_0000, 32'h1234_5678};

  typedef logic [37:0] wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_req = 1'b0;
  logic [3:0]  cfg_sel = '0;
  logic        busy, done, error, cur_valid, mgmt_write, mgmt_read;
  logic [3:0]  cur_preset;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata = '0;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_cur  = 0;
  bit m_valid = 1'b0;
  bit lock_pat[$];

  always #5 clk = ~clk;

  pll_cfg_seq #(
    .N_PRESETS    (NP),
    .N_CLOCKS     (NC),
    .PRESET_M     (PM),
    .PRESET_N     (PN),
    .PRESET_C     (PC),
    .PRESET_K     (PK),
    .POLL_TIMEOUT (PTMO),
    .LOCK_TIMEOUT (LTMO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_req          (cfg_req),
    .cfg_sel          (cfg_sel),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .cur_preset       (cur_preset),
    .cur_valid        (cur_valid),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_read        (mgmt_read),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_locked       (pll_locked)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] word18(input logic [161:0] v, input int k);
    logic [161:0] s;
    s = v >> (18 * k);
    return s[17:0];
  endfunction

  function automatic logic [31:0] word32(input logic [95:0] v, input int k);
    logic [95:0] s;
    s = v >> (32 * k);
    return s[31:0];
  endfunction

  // Cycles spent in LOCK: first point where four consecutive highs have been seen (pattern then stays high).
  function automatic int lock_len;
    int run = 0;
    for (int k = 0; k < 1000; k++) begin
      run = ((k < lock_pat.size()) ? lock_pat[k] : 1'b1) ? run + 1 : 0;
      if (run == 4) return k + 1;
    end
    return 1000;
  endfunction

  task automatic run_req(input int sel, input int pz, input int st_idx, input bit rnd,
                         input int rst_idx);
    wr_t exp_q[$];
    wr_t got_q[$];
    int t = 0, t_end = 0, n_done = 0, n_err = 0, n_rd = 0, n_wr = 0, bad_ra = 0;
    int unstable = 0, stall_left = 0, stall_sum = 0, busy_gap = 0, both = 0, lk = 0;
    int exp_end, exp_rd;
    bit in_wr = 0, lock_on = 0, fin = 0, aborted = 0, exp_bad, exp_short, exp_tmo;
    logic [5:0]  ha = '0;
    logic [31:0] hd = '0;
    logic [31:0] r;

    exp_bad   = (sel >= NP);
    exp_short = !exp_bad && m_valid && (sel == m_cur);
    exp_tmo   = !exp_bad && !exp_short && (pz < 0);
    if (!exp_bad && !exp_short) begin
      exp_q.push_back({6'h00, 32'd1});
      exp_q.push_back({6'h04, 32'(word18(PM, sel))});
      exp_q.push_back({6'h03, 32'(word18(PN, sel))});
      for (int i = 0; i < NC; i++)
        exp_q.push_back({6'h05, (32'(i) << 18) | 32'(word18(PC, sel * NC + i))});
      exp_q.push_back({6'h07, word32(PK, sel)});
      exp_q.push_back({6'h02, 32'd0});
    end

    cfg_sel = 4'(sel);
    cfg_req = 1'b1;
    step;
    cfg_req = 1'b0;
    cfg_sel = 4'($urandom);

    while (!fin && t < 3000) begin
      t++;
      if (done)  n_done++;
      if (error) n_err++;
      if (done || error) begin
        fin = 1;
        t_end = t;
      end else if (!busy) busy_gap++;
      if (mgmt_write && mgmt_read) both++;
      mgmt_waitrequest = 1'b0;
      mgmt_readdata    = '0;
      pll_locked       = 1'b0;
      if (lock_on) begin
        pll_locked = (lk < lock_pat.size()) ? lock_pat[lk] : 1'b1;
        lk++;
      end
      if (mgmt_write) begin
        if (!in_wr) begin
          in_wr = 1;
          ha = mgmt_address;
          hd = mgmt_writedata;
          if (n_wr == rst_idx) begin
            rst = 1'b1;
            step;
            rst = 1'b0;
            check("rst_write", mgmt_write, 1'b0);
            check("rst_read",  mgmt_read,  1'b0);
            check("rst_busy",  busy,       1'b0);
            check("rst_pulse", {done, error}, 2'b00);
            m_valid = 1'b0;
            m_cur   = 0;
            aborted = 1;
            fin     = 1;
            break;
          end
          stall_left = (n_wr == st_idx) ? 5 : (rnd ? int'($urandom_range(0, 2)) : 0);
          stall_sum += stall_left;
        end else if (mgmt_address !== ha || mgmt_writedata !== hd) unstable++;
        if (stall_left > 0) begin
          mgmt_waitrequest = 1'b1;
          stall_left--;
        end else begin
          got_q.push_back({mgmt_address, mgmt_writedata});
          in_wr = 0;
          n_wr++;
        end
      end else if (mgmt_read) begin
        n_rd++;
        if (mgmt_address !== 6'h01) bad_ra++;
        r = $urandom;
        if (pz >= 0 && n_rd > pz) begin
          mgmt_readdata = r | 32'h1;
          lock_on = 1;
        end else mgmt_readdata = r & ~32'h1;
      end
      step;
    end
    mgmt_waitrequest = 1'b0;
    pll_locked = 1'b0;
    if (aborted) return;

    check("finished", fin, 1'b1);
    check("pulse_once", {done, error}, 2'b00);
    if (exp_bad || exp_short) begin
      exp_end = 1;
      exp_rd  = 0;
    end else if (exp_tmo) begin
      exp_end = 1 + exp_q.size() + stall_sum + PTMO;
      exp_rd  = PTMO;
    end else begin
      exp_end = 1 + exp_q.size() + stall_sum + (pz + 1) + lock_len();
      exp_rd  = pz + 1;
    end
    check("n_done",  n_done, (exp_bad || exp_tmo) ? 0 : 1);
    check("n_error", n_err,  (exp_bad || exp_tmo) ? 1 : 0);
    check("end_cycle", t_end, exp_end);
    check("n_writes", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("write%0d", i), got_q[i], exp_q[i]);
    check("n_reads", n_rd, exp_rd);
    check("read_addr_bad", bad_ra, 0);
    check("write_unstable", unstable, 0);
    check("busy_gap", busy_gap, 0);
    check("rd_wr_overlap", both, 0);
    check("busy_end", busy, 1'b0);
    if (!exp_bad && !exp_short) begin
      if (exp_tmo) m_valid = 1'b0;
      else begin
        m_valid = 1'b1;
        m_cur   = sel;
      end
    end
    check("cur_valid", cur_valid, m_valid);
    if (m_valid) check("cur_preset", cur_preset, 4'(m_cur));
    step;
  endtask

  initial begin
    int sel, pz, len;
    step;
    step;
    check("rst_busy",   busy,           1'b0);
    check("rst_done",   done,           1'b0);
    check("rst_error",  error,          1'b0);
    check("rst_cur",    cur_preset,     4'd0);
    check("rst_valid",  cur_valid,      1'b0);
    check("rst_mwrite", mgmt_write,     1'b0);
    check("rst_mread",  mgmt_read,      1'b0);
    check("rst_addr",   mgmt_address,   6'd0);
    check("rst_wdata",  mgmt_writedata, 32'd0);
    rst = 1'b0;
    step;

    lock_pat.delete();
    run_req(1, 1, -1, 0, -1);
    run_req(1, 0, -1, 0, -1);
    run_req(2, 0, 4, 0, -1);
    run_req(5, 0, -1, 0, -1);
    run_req(0, -1, -1, 0, -1);
    lock_pat = '{1, 1, 0, 1, 1, 1, 1};
    run_req(0, 0, -1, 0, -1);

    for (int it = 0; it < 6; it++) begin
      sel = int'($urandom_range(0, 3));
      pz  = int'($urandom_range(0, 3));
      len = int'($urandom_range(0, 6));
      lock_pat.delete();
      for (int k = 0; k < len; k++) lock_pat.push_back(1'($urandom));
      run_req(sel, pz, -1, 1, -1);
    end

    lock_pat.delete();
    sel = m_valid ? (m_cur + 1) % NP : 1;
    run_req(sel, 0, -1, 0, 4);
    step;
    run_req(2, 0, -1, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
